// File: rtl/rx_axis_pkg.sv
// Shared types and helpers for the receive-side AXI4-Stream reader.
// Word count and byte-enable helpers are sized for 256-bit words and 14-bit lengths.
package rx_axis_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEN_WAIT = 2'd1,
    STREAM   = 2'd2
  } state_t;

  localparam int WORD_BYTES = 32;

  function automatic logic [9:0] len2words(input logic [13:0] len);
    logic [14:0] sum;
    sum = {1'b0, len} + 15'd31;
    return sum[14:5];
  endfunction

  // n in 1..32; n==32 gives all ones
  function automatic logic [31:0] bytes2keep(input logic [5:0] n);
    logic [32:0] one_hot;
    one_hot = 33'd1 << n;
    return 32'(one_hot - 33'd1);
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry first-word-fall-through buffer with occupancy output.
// The head entry only changes when it is popped, so read data holds while stalled.
module axis_skid2 #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   occ,
  output logic         valid
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign pop     = rd_en && (occ != 2'd0);
  assign rd_data = head;
  assign valid   = (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case ({wr_en, pop})
        2'b10: begin
          if (occ == 2'd0) head <= wr_data;
          else             tail <= wr_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (occ == 2'd1) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_axis_reader.sv
// Drains the receive data/length FIFOs and presents each packet as an AXI4-Stream master.
// tkeep/tlast come from the stored byte length; a 2-entry buffer hides the FIFO read latency.
module rx_axis_reader
  import rx_axis_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int KEEPW = 32,
  parameter int PTR   = 10,
  parameter int LENW  = 14
) (
  input  logic             clk,
  input  logic             reset,
  output logic             dfifo_rden,
  input  logic [WIDTH-1:0] dfifo_dataout,
  input  logic             dfifo_rdempty,
  input  logic [PTR:0]     dfifo_rdusedw,
  output logic             lfifo_rden,
  input  logic [LENW-1:0]  lfifo_dataout,
  input  logic             lfifo_rdempty,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [KEEPW-1:0] m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      pkt_cnt,
  output logic             err_zero_len,
  output logic             dbg
);

  state_t           state;
  state_t           state_nxt;
  logic [9:0]       rd_left;
  logic [9:0]       out_left;
  logic [5:0]       last_bytes;
  logic             inflight;
  logic [1:0]       occ;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             is_last;
  logic             len_zero;
  logic [2:0]       fill;
  logic             unused_rdusedw;

  assign unused_rdusedw = ^dfifo_rdusedw;

  assign pop      = head_valid && m_axis_tready;
  assign is_last  = (out_left == 10'd1);
  assign len_zero = (lfifo_dataout == '0);
  // buffer slots committed after this cycle's pop
  assign fill     = 3'(occ) + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!lfifo_rdempty) state_nxt = LEN_WAIT;
      LEN_WAIT: state_nxt = len_zero ? IDLE : STREAM;
      STREAM:   if (pop && is_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lfifo_rden   = 1'b0;
    dfifo_rden   = 1'b0;
    err_zero_len = 1'b0;
    dbg          = 1'b0;
    if (!reset) begin
      lfifo_rden   = (state == IDLE) && !lfifo_rdempty;
      dfifo_rden   = (state == STREAM) && !dfifo_rdempty &&
                     (rd_left != 10'd0) && (fill < 3'd2);
      err_zero_len = (state == LEN_WAIT) && len_zero;
      dbg          = (state != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_left    <= 10'd0;
      out_left   <= 10'd0;
      last_bytes <= 6'd0;
      inflight   <= 1'b0;
      pkt_cnt    <= 32'd0;
    end else begin
      inflight <= dfifo_rden;
      if (state == LEN_WAIT && !len_zero) begin
        rd_left    <= len2words(lfifo_dataout);
        out_left   <= len2words(lfifo_dataout);
        last_bytes <= (lfifo_dataout[4:0] == 5'd0) ? 6'(WORD_BYTES)
                                                   : {1'b0, lfifo_dataout[4:0]};
      end else begin
        if (dfifo_rden) rd_left  <= rd_left - 10'd1;
        if (pop)        out_left <= out_left - 10'd1;
      end
      if (pop && is_last) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  axis_skid2 #(.W(WIDTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (dfifo_dataout),
    .rd_en   (pop),
    .rd_data (head_data),
    .occ     (occ),
    .valid   (head_valid)
  );

  assign m_axis_tvalid = head_valid;
  assign m_axis_tdata  = head_data;
  assign m_axis_tlast  = head_valid && is_last;
  assign m_axis_tkeep  = !head_valid ? '0 :
                         is_last     ? KEEPW'(bytes2keep(last_bytes)) : '1;

endmodule

// File: tb/tb_rx_axis_reader.sv
// Directed bench for rx_axis_reader: behavioural data/length FIFOs, output capture,
// and checks on ordering, tkeep/tlast, latency, gaps, stalls and reset.
module tb_rx_axis_reader;

  localparam int WIDTH = 256;
  localparam int KEEPW = 32;
  localparam int PTR   = 10;
  localparam int LENW  = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             dfifo_rden;
  logic [WIDTH-1:0] dfifo_dataout = '0;
  logic             dfifo_rdempty = 1'b1;
  logic [PTR:0]     dfifo_rdusedw = '0;
  logic             lfifo_rden;
  logic [LENW-1:0]  lfifo_dataout = '0;
  logic             lfifo_rdempty = 1'b1;
  logic [WIDTH-1:0] m_axis_tdata;
  logic [KEEPW-1:0] m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic [31:0]      pkt_cnt;
  logic             err_zero_len;
  logic             dbg;

  always #5 clk = ~clk;

  rx_axis_reader #(.WIDTH(WIDTH), .KEEPW(KEEPW), .PTR(PTR), .LENW(LENW)) dut (
    .clk           (clk),
    .reset         (reset),
    .dfifo_rden    (dfifo_rden),
    .dfifo_dataout (dfifo_dataout),
    .dfifo_rdempty (dfifo_rdempty),
    .dfifo_rdusedw (dfifo_rdusedw),
    .lfifo_rden    (lfifo_rden),
    .lfifo_dataout (lfifo_dataout),
    .lfifo_rdempty (lfifo_rdempty),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt),
    .err_zero_len  (err_zero_len),
    .dbg           (dbg)
  );

  logic [WIDTH-1:0] dq[$];
  logic [LENW-1:0]  lq[$];
  logic [WIDTH-1:0] exp_data[$];
  logic [31:0]      exp_keep[$];
  logic             exp_last[$];
  logic [WIDTH-1:0] rx_data[$];
  logic [31:0]      rx_keep[$];
  logic             rx_last[$];
  int               rx_cyc[$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   lrd_cyc = 0;
  int   drd_cnt = 0;
  int   err_cnt = 0;
  logic underflow = 1'b0;
  logic rnd_rdy = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFOs with one-cycle read latency; flags reflect contents after this edge's pop
  always @(posedge clk) begin
    if (dfifo_rden) begin
      if (dq.size() == 0) underflow = 1'b1;
      else dfifo_dataout <= dq.pop_front();
    end
    if (lfifo_rden) begin
      if (lq.size() == 0) underflow = 1'b1;
      else lfifo_dataout <= lq.pop_front();
    end
    dfifo_rdempty <= (dq.size() == 0);
    lfifo_rdempty <= (lq.size() == 0);
    dfifo_rdusedw <= 11'(dq.size());
  end

  always @(posedge clk) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_keep.push_back(m_axis_tkeep);
      rx_last.push_back(m_axis_tlast);
      rx_cyc.push_back(cyc);
    end
    if (lfifo_rden)   lrd_cyc = cyc;
    if (dfifo_rden)   drd_cnt++;
    if (err_zero_len) err_cnt++;
    cyc = cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic             stall_q = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic [31:0]      hold_keep;
  logic             hold_last;

  always @(negedge clk) begin
    if (!reset) begin
      check("occ_le2", 1'((int'(dut.inflight) + int'(dut.u_buf.occ)) <= 2), 1);
      if (stall_q) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data", m_axis_tdata, hold_data);
        check("stall_keep", m_axis_tkeep, hold_keep);
        check("stall_last", m_axis_tlast, hold_last);
      end
    end
    stall_q   = !reset && m_axis_tvalid && !m_axis_tready;
    hold_data = m_axis_tdata;
    hold_keep = m_axis_tkeep;
    hold_last = m_axis_tlast;
  end

  function automatic logic [WIDTH-1:0] mkword(input int pid, input int w);
    return {8{pid[15:0], w[15:0]}};
  endfunction

  function automatic logic [31:0] keep_for(input int len);
    int nb;
    nb = len % 32;
    if (nb == 0) return 32'hFFFF_FFFF;
    return (32'h1 << nb) - 32'h1;
  endfunction

  task automatic push_len_exp(input int len, input int pid);
    int nw;
    nw = (len + 31) / 32;
    lq.push_back(LENW'(len));
    for (int w = 0; w < nw; w++) begin
      exp_data.push_back(mkword(pid, w));
      exp_keep.push_back((w == nw - 1) ? keep_for(len) : 32'hFFFF_FFFF);
      exp_last.push_back(w == nw - 1);
    end
  endtask

  task automatic push_data(input int pid, input int from, input int to);
    for (int w = from; w < to; w++) dq.push_back(mkword(pid, w));
  endtask

  task automatic push_pkt(input int len, input int pid);
    push_len_exp(len, pid);
    push_data(pid, 0, (len + 31) / 32);
  endtask

  task automatic clear_rx();
    rx_data.delete(); rx_keep.delete(); rx_last.delete(); rx_cyc.delete();
  endtask

  task automatic wait_words(input int n, input int budget);
    int i;
    i = 0;
    while (rx_data.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check("word_count", rx_data.size(), n);
  endtask

  task automatic score();
    int n;
    n = (rx_data.size() < exp_data.size()) ? rx_data.size() : exp_data.size();
    check("score_count", rx_data.size(), exp_data.size());
    for (int i = 0; i < n; i++) begin
      check("score_data", rx_data[i], exp_data[i]);
      check("score_keep", rx_keep[i], exp_keep[i]);
      check("score_last", rx_last[i], exp_last[i]);
    end
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    clear_rx();
  endtask

  task automatic check_reset_vals();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tkeep", m_axis_tkeep, 32'h0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_pkt_cnt", pkt_cnt, 32'd0);
    check("rst_err", err_zero_len, 1'b0);
    check("rst_dbg", dbg, 1'b0);
    check("rst_drden", dfifo_rden, 1'b0);
    check("rst_lrden", lfifo_rden, 1'b0);
  endtask

  initial begin
    int base_rd;
    int base_err;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    // 64 bytes: two full words
    push_pkt(64, 1);
    wait_words(2, 50);
    check("a_keep0", rx_keep[0], 32'hFFFF_FFFF);
    check("a_keep1", rx_keep[1], 32'hFFFF_FFFF);
    check("a_last0", rx_last[0], 1'b0);
    check("a_last1", rx_last[1], 1'b1);
    check("a_latency", rx_cyc[0] - lrd_cyc, 4);
    check("a_pkt_cnt", pkt_cnt, 32'd1);
    score();

    // 65 / 33 / 31 bytes
    push_pkt(65, 2);
    push_pkt(33, 3);
    push_pkt(31, 4);
    wait_words(6, 100);
    check("b65_keep", rx_keep[2], 32'h0000_0001);
    check("b65_last", rx_last[2], 1'b1);
    check("b33_keep0", rx_keep[3], 32'hFFFF_FFFF);
    check("b33_keep", rx_keep[4], 32'h0000_0001);
    check("b31_keep", rx_keep[5], 32'h7FFF_FFFF);
    check("b31_last", rx_last[5], 1'b1);
    check("b_pkt_cnt", pkt_cnt, 32'd4);
    score();

    // ten back-to-back 512-byte packets
    for (int p = 0; p < 10; p++) push_pkt(512, 10 + p);
    wait_words(160, 1000);
    for (int p = 0; p < 10; p++) begin
      for (int w = 1; w < 16; w++)
        check("c_rate", rx_cyc[16*p + w] - rx_cyc[16*p + w - 1], 1);
      if (p > 0)
        check("c_gap", 1'((rx_cyc[16*p] - rx_cyc[16*p - 1]) >= 5), 1'b1);
    end
    check("c_pkt_cnt", pkt_cnt, 32'd14);
    score();

    // 1500 bytes under random backpressure
    rnd_rdy = 1'b1;
    push_pkt(1500, 30);
    wait_words(47, 2000);
    check("d_keep", rx_keep[46], 32'h0FFF_FFFF);
    check("d_last", rx_last[46], 1'b1);
    check("d_pkt_cnt", pkt_cnt, 32'd15);
    score();
    rnd_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // zero-length descriptor, then 32 bytes
    base_rd  = drd_cnt;
    base_err = err_cnt;
    push_len_exp(0, 39);
    push_pkt(32, 40);
    wait_words(1, 50);
    repeat (5) @(negedge clk);
    check("e_err_pulses", err_cnt - base_err, 1);
    check("e_reads", drd_cnt - base_rd, 1);
    check("e_keep", rx_keep[0], 32'hFFFF_FFFF);
    check("e_last", rx_last[0], 1'b1);
    check("e_pkt_cnt", pkt_cnt, 32'd16);
    score();

    // data FIFO runs dry after word 3 of 8
    push_len_exp(256, 50);
    push_data(50, 0, 3);
    wait_words(3, 50);
    repeat (20) @(negedge clk);
    check("f_hold_count", rx_data.size(), 3);
    check("f_hold_valid", m_axis_tvalid, 1'b0);
    push_data(50, 3, 8);
    wait_words(8, 100);
    check("f_last2", rx_last[2], 1'b0);
    check("f_last7", rx_last[7], 1'b1);
    check("f_pkt_cnt", pkt_cnt, 32'd17);
    score();

    // reset in the middle of a packet
    push_pkt(256, 60);
    begin
      int i;
      i = 0;
      while (rx_data.size() < 3 && i < 50) begin
        @(negedge clk);
        i++;
      end
    end
    check("g_started", 1'(rx_data.size() >= 3), 1'b1);
    reset = 1'b1;
    dq.delete();
    lq.delete();
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    clear_rx();
    repeat (10) @(negedge clk);
    check("g_quiet_words", rx_data.size(), 0);
    check("g_quiet_dbg", dbg, 1'b0);
    push_pkt(64, 70);
    wait_words(2, 50);
    check("g_pkt_cnt", pkt_cnt, 32'd1);
    score();

    check("fifo_underflow", underflow, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
